// File: rtl/axil_reg_slave_if.sv
// ---------------------------------------------------------------------------
// axil_if : AXI4-Lite channel bundle (AW/W/B/AR/R), no IDs or bursts.
//   Master modport : drives AW/W/AR payload+valid, B/R ready.
//   Slave  modport : drives AW/W/AR ready, B/R payload+valid.
//   Parameters     : AXI_ADDR_WIDTH (address bits), AXI_DATA_WIDTH (data bits,
//                    strobe width is AXI_DATA_WIDTH/8).
// ---------------------------------------------------------------------------
interface axil_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
);
  // Write address
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]                  aw_prot;
  logic                        aw_valid;
  logic                        aw_ready;
  // Write data
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_valid;
  logic                        w_ready;
  // Write response
  logic [1:0]                  b_resp;
  logic                        b_valid;
  logic                        b_ready;
  // Read address
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]                  ar_prot;
  logic                        ar_valid;
  logic                        ar_ready;
  // Read data
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_valid, input  aw_ready,
    output w_data, w_strb, w_valid,    input  w_ready,
    input  b_resp, b_valid,            output b_ready,
    output ar_addr, ar_prot, ar_valid, input  ar_ready,
    input  r_data, r_resp, r_valid,    output r_ready
  );

  modport Slave (
    input  aw_addr, aw_prot, aw_valid, output aw_ready,
    input  w_data, w_strb, w_valid,    output w_ready,
    output b_resp, b_valid,            input  b_ready,
    input  ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid,    input  r_ready
  );
endinterface

// File: rtl/axil_reg_slave.sv
// ---------------------------------------------------------------------------
// axil_reg_slave : AXI4-Lite responder exposing NUM_REGS software registers.
//   Independent write and read paths, one outstanding transaction each.
//
// Ports
//   clk_i       in   clock, rising edge
//   rst_i       in   synchronous reset, active-high
//   s_axil      --   axil_if.Slave, AW/W/B/AR/R responder side
//   reg_o       out  register contents, reg k at [32k+31:32k]
//   wr_pulse_o  out  one-cycle pulse on the register written (same cycle
//                    reg_o shows the new value)
//
// Optional feature (compile-time macro AXIL_REG_SLAVE_PROT_CHECK_EN):
//   when defined, accesses with prot[0]=0 (unprivileged) get SLVERR,
//   no register change and r_data=0. Handshake timing is identical.
// ---------------------------------------------------------------------------
module axil_reg_slave #(
  parameter int unsigned               AXI_ADDR_WIDTH = 32,
  parameter int unsigned               AXI_DATA_WIDTH = 32,
  parameter int unsigned               NUM_REGS       = 8,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [AXI_DATA_WIDTH-1:0] RESET_VAL      = '0
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  axil_if.Slave                              s_axil,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_o,
  output logic [NUM_REGS-1:0]                wr_pulse_o
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] SPAN = AXI_ADDR_WIDTH'(4 * NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { WR_COLLECT, WR_RESP } wr_state_e;
  typedef enum logic { RD_IDLE,    RD_RESP } rd_state_e;

  // Register bank
  logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Write path state
  wr_state_e                 wr_state_q;
  logic                      aw_ready_q, w_ready_q;
  logic                      aw_have_q, w_have_q;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]         w_strb_q;
  logic                      b_valid_q;
  logic [1:0]                b_resp_q;
  logic [NUM_REGS-1:0]       wr_pulse_q;

  // Read path state
  rd_state_e                 rd_state_q;
  logic                      ar_ready_q;
  logic                      r_valid_q;
  logic [1:0]                r_resp_q;
  logic [AXI_DATA_WIDTH-1:0] r_data_q;

  // Combinational decode
  logic                      aw_hs, w_hs, ar_hs;
  logic                      aw_got, w_got;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr, wr_off, rd_off;
  logic [AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]         wr_strb;
  logic                      wr_ok, rd_ok;
  logic [IDX_W-1:0]          wr_idx, rd_idx;

`ifdef AXIL_REG_SLAVE_PROT_CHECK_EN
  logic aw_priv_q;
  logic wr_priv;
  logic unused_prot;
  assign unused_prot = ^{s_axil.aw_prot[2:1], s_axil.ar_prot[2:1]};
`else
  logic unused_prot;
  assign unused_prot = ^{s_axil.aw_prot, s_axil.ar_prot};
`endif

  // AW and W may land in the same cycle as the commit decision, so the
  // effective address/data come from the buffer if already held, otherwise
  // straight from the bus. This gives the one-cycle AW+W -> B latency.
  //
  // Range check uses only (addr - BASE_ADDR) < SPAN: BASE_ADDR is aligned to a
  // power of two >= SPAN, so any address below BASE_ADDR wraps to an offset of
  // at least SPAN and is rejected without a separate lower-bound compare.
  always_comb begin
    aw_hs   = s_axil.aw_valid && aw_ready_q;
    w_hs    = s_axil.w_valid  && w_ready_q;
    ar_hs   = s_axil.ar_valid && ar_ready_q;
    aw_got  = aw_have_q || aw_hs;
    w_got   = w_have_q  || w_hs;
    wr_addr = aw_have_q ? aw_addr_q : s_axil.aw_addr;
    wr_data = w_have_q  ? w_data_q  : s_axil.w_data;
    wr_strb = w_have_q  ? w_strb_q  : s_axil.w_strb;
    wr_off  = wr_addr - BASE_ADDR;
    wr_idx  = wr_off[IDX_W+1:2];
    rd_off  = s_axil.ar_addr - BASE_ADDR;
    rd_idx  = rd_off[IDX_W+1:2];
`ifdef AXIL_REG_SLAVE_PROT_CHECK_EN
    wr_priv = aw_have_q ? aw_priv_q : s_axil.aw_prot[0];
    wr_ok   = (wr_off < SPAN) && wr_priv;
    rd_ok   = (rd_off < SPAN) && s_axil.ar_prot[0];
`else
    wr_ok   = (wr_off < SPAN);
    rd_ok   = (rd_off < SPAN);
`endif
  end

  // Write FSM and register bank
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= WR_COLLECT;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      aw_have_q  <= 1'b0;
      w_have_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      wr_pulse_q <= '0;
`ifdef AXIL_REG_SLAVE_PROT_CHECK_EN
      aw_priv_q  <= 1'b0;
`endif
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      wr_pulse_q <= '0;
      unique case (wr_state_q)
        WR_COLLECT: begin
          if (aw_got && w_got) begin
            aw_have_q  <= 1'b0;
            w_have_q   <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b1;
            b_resp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok) begin
              for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                  regs_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
              end
              wr_pulse_q[wr_idx] <= 1'b1;
            end
            wr_state_q <= WR_RESP;
          end else begin
            if (aw_hs) begin
              aw_have_q <= 1'b1;
              aw_addr_q <= s_axil.aw_addr;
`ifdef AXIL_REG_SLAVE_PROT_CHECK_EN
              aw_priv_q <= s_axil.aw_prot[0];
`endif
            end
            if (w_hs) begin
              w_have_q <= 1'b1;
              w_data_q <= s_axil.w_data;
              w_strb_q <= s_axil.w_strb;
            end
            aw_ready_q <= !aw_got;
            w_ready_q  <= !w_got;
          end
        end
        WR_RESP: begin
          if (s_axil.b_ready) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            wr_state_q <= WR_COLLECT;
          end
        end
      endcase
    end
  end

  // Read FSM; data is taken from regs_q before any same-edge write lands,
  // so a read accepted in the commit cycle returns the old value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= RD_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
    end else begin
      unique case (rd_state_q)
        RD_IDLE: begin
          if (ar_hs) begin
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b1;
            if (rd_ok) begin
              r_data_q <= regs_q[rd_idx];
              r_resp_q <= RESP_OKAY;
            end else begin
              r_data_q <= '0;
              r_resp_q <= RESP_SLVERR;
            end
            rd_state_q <= RD_RESP;
          end else begin
            ar_ready_q <= 1'b1;
          end
        end
        RD_RESP: begin
          if (s_axil.r_ready) begin
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b1;
            rd_state_q <= RD_IDLE;
          end
        end
      endcase
    end
  end

  assign s_axil.aw_ready = aw_ready_q;
  assign s_axil.w_ready  = w_ready_q;
  assign s_axil.b_valid  = b_valid_q;
  assign s_axil.b_resp   = b_resp_q;
  assign s_axil.ar_ready = ar_ready_q;
  assign s_axil.r_valid  = r_valid_q;
  assign s_axil.r_resp   = r_resp_q;
  assign s_axil.r_data   = r_data_q;
  assign wr_pulse_o      = wr_pulse_q;

  always_comb begin
    reg_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_o[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
module tb_axil_reg_slave;
  localparam int unsigned NR   = 8;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axil_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) bus ();
  logic [NR*32-1:0] reg_o;
  logic [NR-1:0]    wr_pulse;

  axil_reg_slave #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .NUM_REGS(NR),
    .BASE_ADDR(BASE),
    .RESET_VAL(32'h0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .s_axil(bus),
    .reg_o(reg_o),
    .wr_pulse_o(wr_pulse)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_regs [NR];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s reg%0d", tag, i), 64'(reg_o[i*32 +: 32]), 64'(exp_regs[i]));
  endtask

  task automatic check_rdy(input string tag, input logic exp);
    check({tag, " aw_ready"}, 64'(bus.aw_ready), 64'(exp));
    check({tag, " w_ready"},  64'(bus.w_ready),  64'(exp));
  endtask

  // AW and W in the same cycle; B checked the next cycle, then accepted.
  task automatic write_same(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp, input logic [7:0] pulse);
    bus.aw_valid = 1'b1; bus.aw_addr = addr;
    bus.w_valid  = 1'b1; bus.w_data  = data; bus.w_strb = strb;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    check({tag, " b_valid"}, 64'(bus.b_valid), 64'd1);
    check({tag, " b_resp"},  64'(bus.b_resp),  64'(resp));
    check({tag, " pulse"},   64'(wr_pulse),    64'(pulse));
    check_rdy({tag, " in resp"}, 1'b0);
    check_regs(tag);
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    check({tag, " b_valid after hs"}, 64'(bus.b_valid), 64'd0);
    check({tag, " pulse after"},      64'(wr_pulse),    64'd0);
    check_rdy({tag, " after hs"}, 1'b1);
  endtask

  task automatic read(input string tag, input logic [31:0] addr,
                      input logic [31:0] data, input logic [1:0] resp);
    bus.ar_valid = 1'b1; bus.ar_addr = addr;
    check({tag, " ar_ready"}, 64'(bus.ar_ready), 64'd1);
    tick();
    bus.ar_valid = 1'b0;
    check({tag, " r_valid"},  64'(bus.r_valid),  64'd1);
    check({tag, " r_data"},   64'(bus.r_data),   64'(data));
    check({tag, " r_resp"},   64'(bus.r_resp),   64'(resp));
    check({tag, " ar_ready busy"}, 64'(bus.ar_ready), 64'd0);
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    check({tag, " r_valid after hs"}, 64'(bus.r_valid),  64'd0);
    check({tag, " ar_ready after"},   64'(bus.ar_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.aw_prot = 3'b001;
    bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb  = '0;
    bus.b_ready  = 1'b0;
    bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.ar_prot = 3'b001;
    bus.r_ready  = 1'b0;
    for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;

    // Reset state
    repeat (3) tick();
    check_rdy("reset", 1'b0);
    check("reset ar_ready", 64'(bus.ar_ready), 64'd0);
    check("reset b_valid",  64'(bus.b_valid),  64'd0);
    check("reset r_valid",  64'(bus.r_valid),  64'd0);
    check("reset b_resp",   64'(bus.b_resp),   64'd0);
    check("reset r_resp",   64'(bus.r_resp),   64'd0);
    check("reset r_data",   64'(bus.r_data),   64'd0);
    check("reset pulse",    64'(wr_pulse),     64'd0);
    check_regs("reset");
    rst = 1'b0;
    check_rdy("release same cycle", 1'b0);
    tick();
    check_rdy("release next", 1'b1);
    check("release ar_ready", 64'(bus.ar_ready), 64'd1);
    check("release b_valid",  64'(bus.b_valid),  64'd0);
    check("release r_valid",  64'(bus.r_valid),  64'd0);

    // AW+W same cycle, then readback
    exp_regs[2] = 32'hDEAD_BEEF;
    write_same("wr reg2", BASE + 32'd8, 32'hDEAD_BEEF, 4'hF, 2'b00, 8'h04);
    read("rd reg2", BASE + 32'd8, 32'hDEAD_BEEF, 2'b00);
    read("rd reg2 low bits", BASE + 32'd11, 32'hDEAD_BEEF, 2'b00);

    // W first, AW three cycles later, partial strobe, B back-pressure
    bus.w_valid = 1'b1; bus.w_data = 32'h1122_3344; bus.w_strb = 4'b0101;
    tick();
    bus.w_valid = 1'b0;
    check("wfirst w_ready",  64'(bus.w_ready),  64'd0);
    check("wfirst aw_ready", 64'(bus.aw_ready), 64'd1);
    tick();
    tick();
    check("wfirst b_valid early", 64'(bus.b_valid), 64'd0);
    check_regs("wfirst before aw");
    bus.aw_valid = 1'b1; bus.aw_addr = BASE + 32'd4;
    tick();
    bus.aw_valid = 1'b0;
    exp_regs[1] = 32'h0022_0044;
    check_regs("wfirst commit");
    check("wfirst pulse",   64'(wr_pulse),    64'h02);
    check("wfirst b_valid", 64'(bus.b_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold%0d b_valid", i), 64'(bus.b_valid), 64'd1);
      check($sformatf("hold%0d b_resp", i),  64'(bus.b_resp),  64'd0);
      check($sformatf("hold%0d pulse", i),   64'(wr_pulse),    64'd0);
      check_rdy($sformatf("hold%0d", i), 1'b0);
    end
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    check("wfirst b_valid done", 64'(bus.b_valid), 64'd0);
    read("rd reg1", BASE + 32'd4, 32'h0022_0044, 2'b00);

    // Range boundaries
    exp_regs[7] = 32'hCAFE_F00D;
    write_same("wr reg7", BASE + 32'd28, 32'hCAFE_F00D, 4'hF, 2'b00, 8'h80);
    write_same("wr past end", BASE + 32'd32, 32'hFFFF_FFFF, 4'hF, 2'b10, 8'h00);
    write_same("wr below base", BASE - 32'd4, 32'hFFFF_FFFF, 4'hF, 2'b10, 8'h00);
    write_same("wr strb0", BASE + 32'd8, 32'h0000_0000, 4'h0, 2'b00, 8'h04);
    read("rd reg7", BASE + 32'd28, 32'hCAFE_F00D, 2'b00);
    read("rd past end", BASE + 32'd32, 32'h0, 2'b10);
    read("rd below base", BASE - 32'd4, 32'h0, 2'b10);

    // Collision: read in commit cycle sees old value
    bus.aw_valid = 1'b1; bus.aw_addr = BASE;
    bus.w_valid  = 1'b1; bus.w_data  = 32'd5; bus.w_strb = 4'hF;
    bus.ar_valid = 1'b1; bus.ar_addr = BASE;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    exp_regs[0] = 32'd5;
    check("coll same r_data", 64'(bus.r_data), 64'd0);
    check("coll same r_valid", 64'(bus.r_valid), 64'd1);
    check_regs("coll same");
    bus.b_ready = 1'b1; bus.r_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0; bus.r_ready = 1'b0;
    // Read accepted the cycle after commit sees the new value
    bus.aw_valid = 1'b1; bus.aw_addr = BASE;
    bus.w_valid  = 1'b1; bus.w_data  = 32'd9; bus.w_strb = 4'hF;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    exp_regs[0] = 32'd9;
    bus.ar_valid = 1'b1; bus.ar_addr = BASE;
    tick();
    bus.ar_valid = 1'b0;
    check("coll next r_data", 64'(bus.r_data), 64'd9);
    bus.b_ready = 1'b1; bus.r_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0; bus.r_ready = 1'b0;

    // Reset while in WR_RESP with b_ready low
    bus.aw_valid = 1'b1; bus.aw_addr = BASE + 32'd12;
    bus.w_valid  = 1'b1; bus.w_data  = 32'hA5A5_A5A5; bus.w_strb = 4'hF;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    check("pre-rst b_valid", 64'(bus.b_valid), 64'd1);
    rst = 1'b1;
    tick();
    for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
    check("rst b_valid", 64'(bus.b_valid), 64'd0);
    check_rdy("rst", 1'b0);
    check_regs("rst");
    rst = 1'b0;
    tick();
    check_rdy("rst release", 1'b1);

    // Reset with AW captured drops it; later W pairs with a fresh AW
    bus.aw_valid = 1'b1; bus.aw_addr = BASE + 32'd16;
    tick();
    bus.aw_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.w_valid = 1'b1; bus.w_data = 32'h0BAD_F00D; bus.w_strb = 4'hF;
    tick();
    bus.w_valid = 1'b0;
    check("drop b_valid", 64'(bus.b_valid), 64'd0);
    check_regs("drop");
    bus.aw_valid = 1'b1; bus.aw_addr = BASE + 32'd20;
    tick();
    bus.aw_valid = 1'b0;
    exp_regs[5] = 32'h0BAD_F00D;
    check("drop pulse", 64'(wr_pulse), 64'h20);
    check_regs("drop commit");
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;

`ifdef AXIL_REG_SLAVE_PROT_CHECK_EN
    bus.aw_prot = 3'b000;
    write_same("wr unpriv", BASE + 32'd24, 32'h1234_5678, 4'hF, 2'b10, 8'h00);
    bus.aw_prot = 3'b001;
    bus.ar_prot = 3'b000;
    read("rd unpriv", BASE + 32'd20, 32'h0, 2'b10);
    bus.ar_prot = 3'b001;
`endif
    read("rd reg5", BASE + 32'd20, 32'h0BAD_F00D, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
